// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: holds the C908 in reset during host IRAM/SRAM load and
// releases it once the load is quiet; re-enters reset on request, lock loss or watchdog.
module cpu_boot_ctrl #(
    parameter int HOLD_CYCLES  = 16,
    parameter int QUIET_CYCLES = 64,
    parameter int WDT_CYCLES   = 0
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_locked,
    input  logic        I_force_rst,
    input  logic        I_isa_wren,
    input  logic        I_sys_wren,
    input  logic        I_retire,
    output logic        O_cpu_rst_b,
    output logic [1:0]  O_state,
    output logic [15:0] O_isa_wr_cnt,
    output logic [15:0] O_sys_wr_cnt,
    output logic        O_wdt_expired,
    output logic        O_err_wr
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_LOAD  = 2'd1,
        S_QUIET = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] QUIET_LAST = 32'(QUIET_CYCLES - 1);
    localparam logic [31:0] WDT_LAST   = 32'(WDT_CYCLES - 1);

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [15:0] isa_cnt, isa_cnt_n;
    logic [15:0] sys_cnt, sys_cnt_n;
    logic        wdt, wdt_n;
    logic        err, err_n;
    logic        force_m, force_s, force_q;
    logic        force_rise;
    logic        any_wr;
    logic        load_entry;
    logic        count_wr;

    assign force_rise = force_s & ~force_q;
    assign any_wr     = I_isa_wren | I_sys_wren;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        isa_cnt_n  = isa_cnt;
        sys_cnt_n  = sys_cnt;
        wdt_n      = wdt;
        err_n      = err;
        load_entry = 1'b0;
        count_wr   = 1'b0;

        if (!I_locked) begin
            state_n = S_HOLD;
            cnt_n   = '0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (force_s) begin
                        load_entry = 1'b1;
                    end else begin
                        if (any_wr) err_n = 1'b1;
                        if (cnt == HOLD_LAST) begin
                            state_n = S_RUN;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 32'd1;
                        end
                    end
                end
                S_LOAD: begin
                    cnt_n    = '0;
                    count_wr = 1'b1;
                    if (!force_s) state_n = S_QUIET;
                end
                S_QUIET: begin
                    if (force_s) begin
                        load_entry = 1'b1;
                    end else begin
                        count_wr = 1'b1;
                        if (any_wr) begin
                            cnt_n = '0;
                        end else if (cnt == QUIET_LAST) begin
                            state_n = S_RUN;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 32'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (force_rise) begin
                        load_entry = 1'b1;
                    end else begin
                        if (any_wr) err_n = 1'b1;
                        if (WDT_CYCLES != 0) begin
                            if (I_retire) begin
                                cnt_n = '0;
                            end else if (cnt == WDT_LAST) begin
                                wdt_n   = 1'b1;
                                state_n = S_HOLD;
                                cnt_n   = '0;
                            end else begin
                                cnt_n = cnt + 32'd1;
                            end
                        end
                    end
                end
            endcase
        end

        // A fresh load starts with clean counters and flags.
        if (load_entry) begin
            state_n   = S_LOAD;
            cnt_n     = '0;
            isa_cnt_n = '0;
            sys_cnt_n = '0;
            wdt_n     = 1'b0;
            err_n     = 1'b0;
        end

        if (count_wr) begin
            if (I_isa_wren && isa_cnt != 16'hFFFF) isa_cnt_n = isa_cnt + 16'd1;
            if (I_sys_wren && sys_cnt != 16'hFFFF) sys_cnt_n = sys_cnt + 16'd1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state   <= S_HOLD;
            cnt     <= '0;
            isa_cnt <= '0;
            sys_cnt <= '0;
            wdt     <= 1'b0;
            err     <= 1'b0;
            force_m <= 1'b0;
            force_s <= 1'b0;
            force_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            isa_cnt <= isa_cnt_n;
            sys_cnt <= sys_cnt_n;
            wdt     <= wdt_n;
            err     <= err_n;
            force_m <= I_force_rst;
            force_s <= force_m;
            force_q <= force_s;
        end
    end

    assign O_cpu_rst_b   = (state == S_RUN);
    assign O_state       = state;
    assign O_isa_wr_cnt  = isa_cnt;
    assign O_sys_wr_cnt  = sys_cnt;
    assign O_wdt_expired = wdt;
    assign O_err_wr      = err;

endmodule

// File: doc/cpu_boot_ctrl.md
# cpu_boot_ctrl

Boot and reset sequencer for the C908 SoC, on `cpu_clock_100`, directly upstream of the SoC `i_pad_rst_b` pin.
- Holds the CPU in reset while the host loads IRAM/SRAM over PXIe.
- Releases reset only after the load has gone quiet.
- Re-enters reset on host request, clock-lock loss or retire-watchdog expiry.
- Takes the force-reset level from the PXIe RX stage and the post-CDC write strobes from the 128-bit ISA/SYS buffers.

## Interface
Parameters:
- HOLD_CYCLES, 16: qualified cycles in HOLD before release to RUN.
- QUIET_CYCLES, 64: write-free cycles in QUIET before release to RUN.
- WDT_CYCLES, 0: max cycles in RUN without `I_retire`; 0 disables the watchdog.

Ports:
- I_clk  in  1  CPU clock (`cpu_clock_100`); the only clock.
- I_rst  in  1  synchronous, active-high reset.
- I_locked  in  1  `cpu_clk` MMCM locked; synchronous to I_clk.
- I_force_rst  in  1  host load request level from PXIE_RX_DATA, asynchronous; 1 = hold CPU / load in progress.
- I_isa_wren  in  1  IRAM write strobe (post-CDC).
- I_sys_wren  in  1  SRAM write strobe (post-CDC).
- I_retire  in  1  CPU instruction-retire pulse.
- O_cpu_rst_b  out  1  to SoC `i_pad_rst_b`; 0 = CPU in reset.
- O_state  out  2  0 HOLD, 1 LOAD, 2 QUIET, 3 RUN.
- O_isa_wr_cnt  out  16  IRAM writes accepted in the current load.
- O_sys_wr_cnt  out  16  SRAM writes accepted in the current load.
- O_wdt_expired  out  1  sticky watchdog-expiry flag.
- O_err_wr  out  1  sticky flag: write strobe seen in HOLD or RUN.

## Operation
- I_force_rst passes through a 2-flop synchronizer to give `force_s`. Rising edge: `force_s`=1 while prior sample=0.
- `cnt` is one internal 32-bit cycle counter.
- O_cpu_rst_b = (state==RUN), decoded from the state register. There is no combinational path from any input.
- Reset (I_rst=1): state HOLD, cnt 0, O_cpu_rst_b 0, O_state 0, both write counters 0, both sticky flags 0. This holds from any state, including mid-load.
- Lock loss: I_locked=0 in any state → HOLD, cnt=0. This has the highest priority after I_rst.
- HOLD:
  - If force_s=1 → LOAD.
  - Otherwise cnt increments. When cnt==HOLD_CYCLES-1 → RUN, cnt=0.
- LOAD:
  - On entry, clear both write counters, O_wdt_expired and O_err_wr.
  - Each strobe increments its own counter. Simultaneous isa+sys strobes increment both.
  - Counters saturate at 16'hFFFF.
  - When force_s=0 → QUIET, cnt=0.
- QUIET:
  - Writes are still counted.
  - Any strobe resets cnt to 0.
  - force_s=1 → LOAD. Counters are cleared on entry.
  - cnt==QUIET_CYCLES-1 with no strobe that cycle → RUN, cnt=0.
- RUN:
  - Rising edge of force_s → LOAD.
  - A strobe sets O_err_wr and is not counted. The same applies in HOLD.
  - If WDT_CYCLES≠0: I_retire clears cnt, otherwise cnt increments. When cnt==WDT_CYCLES-1 with no retire that cycle, set O_wdt_expired and go to HOLD, cnt=0.
- Transition priority within a cycle: I_rst > lock loss > force > write/retire > count expiry.

## Timing
- I_force_rst rising at edge k: force_s=1 after edge k+2, state LOAD after edge k+3. O_cpu_rst_b therefore falls 3 cycles after the input.
- force_s falling to QUIET takes 3 cycles by the same path.
- From QUIET entry with no writes, RUN is reached after exactly QUIET_CYCLES edges.
- From HOLD with lock stable and force_s=0, RUN is reached after exactly HOLD_CYCLES edges.
- Write counters update on the edge that samples the strobe; the new value is visible the next cycle.
- Watchdog: with no retires, HOLD is reached WDT_CYCLES edges after RUN entry. O_wdt_expired rises on the same edge.
- Sticky flags clear only on I_rst or on LOAD entry.

## Test plan
- Power-up, HOLD=4, I_locked=1, I_force_rst=0 → O_state 0→3 after 4 edges from reset release; O_cpu_rst_b=1.
- Load sequence, QUIET=8:
  - Stimulus: force high, then 5 isa + 3 sys strobes with one simultaneous pair, then force low.
  - Required: O_cpu_rst_b=0 three cycles after force rises; counts 5/3; RUN 8 edges after QUIET entry.
- QUIET restart: strobe at QUIET cnt=6 → cnt resets; RUN delayed to 8 edges after that strobe; count increments.
- Lock loss mid-LOAD: I_locked=0 → HOLD next edge, O_cpu_rst_b stays 0. Lock restored with force still high → LOAD, counters cleared.
- Watchdog, WDT=32:
  - Retire every 10 cycles for 100 cycles → stays in RUN.
  - Then stop retires → HOLD 32 edges after the last retire; O_wdt_expired=1 until the next LOAD entry.
- Write in RUN → O_err_wr=1, counters unchanged. I_rst mid-LOAD → all outputs at reset values on the next edge.
